univ_reg: RTL and testbench
===========================

UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; the module SHALL support WIDTH from 2 to 64.
REQ-002 Parameter CNT_W, default 3, width of the step-count input AMT.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  reset, asynchronous and active-low.
REQ-005 LOAD  input  1  parallel-load request, accepted only in IDLE.
REQ-006 D  input  WIDTH  parallel-load data.
REQ-007 START  input  1  operation request, accepted only in IDLE.
REQ-008 MODE  input  3  operation code, sampled with START.
REQ-009 AMT  input  CNT_W  number of steps, sampled with START.
REQ-010 SIN_L  input  1  serial-in bit entering the MSB on shr.
REQ-011 SIN_R  input  1  serial-in bit entering the LSB on shl.
REQ-012 Q  output  WIDTH  register contents.
REQ-013 COUT  output  1  bit shifted or rotated out, or carry/borrow, from the last applied step.
REQ-014 BUSY  output  1  high whenever state is not IDLE.
REQ-015 DONE  output  1  one-cycle completion pulse.

Function
REQ-016 MODE encoding SHALL be:
- 000 hold
- 001 shl (LSB<=SIN_R)
- 010 shr (MSB<=SIN_L)
- 011 rotl
- 100 rotr
- 101 increment mod 2^WIDTH
- 110 decrement mod 2^WIDTH
- 111 arithmetic shift right (MSB replicated)
REQ-017 FSM states SHALL be IDLE, RUN, FIN.
REQ-018 In IDLE with LOAD=1: next edge Q<=D, COUT<=0, state stays IDLE.
REQ-019 In IDLE with START=1 and LOAD=0: MODE and AMT latched at edge k; next state RUN if AMT!=0, else FIN.
REQ-020 In IDLE with LOAD=1 and START=1 on the same edge: LOAD SHALL win and START SHALL be dropped.
REQ-021 In RUN: the latched op is applied once per edge, on edges k+1..k+AMT; after the AMT-th step, state becomes FIN.
REQ-022 In FIN: DONE=1 for exactly one cycle, then IDLE. With AMT=0, DONE is high in the cycle after edge k and Q/COUT are unchanged.
REQ-023 LOAD and START in RUN or FIN SHALL be ignored, not queued. D, MODE and AMT changes during RUN SHALL have no effect.
REQ-024 COUT per applied step:
- shl, rotl: old MSB
- shr, rotr, asr: old LSB
- inc: carry out
- dec: borrow
- hold: unchanged
REQ-025 Wrap-around: inc of all-ones gives 0 with COUT=1; dec of 0 gives all-ones with COUT=1.
REQ-026 Outputs Q and COUT SHALL be registered. BUSY and DONE SHALL be decoded from state only, with no combinational path from inputs.

Reset
REQ-027 RESET=0 SHALL immediately force Q=0, COUT=0, state=IDLE, BUSY=0, DONE=0, and clear the latched MODE and AMT, including mid-RUN.
REQ-028 After RESET deasserts, the first edge SHALL accept LOAD/START normally.

Structure
REQ-029 Shared package univ_reg_pkg SHALL hold the MODE code constants and the FSM state encoding.
REQ-030 The one-step datapath (op, Q, SIN_L, SIN_R -> next Q, next COUT) SHALL be a combinational sub-module univ_reg_alu, instantiated once.
REQ-031 Step counter SHALL be CNT_W bits, loaded with AMT and decremented in RUN.

Verification (WIDTH=8, CNT_W=3)
REQ-032 LOAD D=0x81, then START shl AMT=1 SIN_R=0 -> Q=0x02, COUT=1, DONE one cycle after the step.
REQ-033 Q=0x81, START rotr AMT=3 -> Q=0xC0, 0x60, 0x30 on successive edges; COUT=0; BUSY high 4 cycles.
REQ-034 Q=0xFE, START inc AMT=2 -> Q=0xFF then 0x00, COUT=1; Q=0x00, dec AMT=1 -> Q=0xFF, COUT=1.
REQ-035 Q=0x80, START asr AMT=3 -> Q=0xF0, COUT=0; START with AMT=0 -> Q unchanged, DONE pulse next cycle.
REQ-036 LOAD=1 and START=1 together in IDLE -> Q=D, BUSY stays 0; LOAD during RUN -> ignored, Q follows op.
REQ-037 RESET=0 asserted mid-RUN between edges -> Q=0x00, BUSY=0, DONE=0 immediately; no DONE pulse afterwards.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal shift/count register: operation codes
// and controller state encoding.
package univ_reg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROTL = 3'b011,
    MODE_ROTR = 3'b100,
    MODE_INC  = 3'b101,
    MODE_DEC  = 3'b110,
    MODE_ASR  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/univ_reg_alu.sv
// One-step combinational datapath: applies a single operation to the register
// value and produces the next value plus the shifted-out / carry bit.
module univ_reg_alu
  import univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e             op,
  input  logic [WIDTH-1:0]  q,
  input  logic              cout,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q_nxt_c,
  output logic              cout_nxt_c
);

  always_comb begin
    q_nxt_c    = q;
    cout_nxt_c = cout;
    case (op)
      MODE_HOLD: begin
        q_nxt_c    = q;
        cout_nxt_c = cout;
      end
      MODE_SHL: begin
        q_nxt_c    = {q[WIDTH-2:0], sin_r};
        cout_nxt_c = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt_c    = {sin_l, q[WIDTH-1:1]};
        cout_nxt_c = q[0];
      end
      MODE_ROTL: begin
        q_nxt_c    = {q[WIDTH-2:0], q[WIDTH-1]};
        cout_nxt_c = q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_nxt_c    = {q[0], q[WIDTH-1:1]};
        cout_nxt_c = q[0];
      end
      MODE_INC: begin
        {cout_nxt_c, q_nxt_c} = (WIDTH+1)'(q) + (WIDTH+1)'(1);
      end
      // Borrow occurs only when decrementing zero.
      MODE_DEC: begin
        q_nxt_c    = q - WIDTH'(1);
        cout_nxt_c = (q == '0);
      end
      MODE_ASR: begin
        q_nxt_c    = {q[WIDTH-1], q[WIDTH-1:1]};
        cout_nxt_c = q[0];
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Universal register: parallel load, and multi-step shift/rotate/count
// operations sequenced by an IDLE/RUN/FIN controller.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  d,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [CNT_W-1:0]  amt,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic              cout,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_load_c, do_start_c, do_step_c;
  logic [WIDTH-1:0]   alu_q_c;
  logic               alu_cout_c;

  univ_reg_alu #(.WIDTH(WIDTH)) u_alu (
    .op         (mode_q),
    .q          (q),
    .cout       (cout),
    .sin_l      (sin_l),
    .sin_r      (sin_r),
    .q_nxt_c    (alu_q_c),
    .cout_nxt_c (alu_cout_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // LOAD outranks START; requests outside IDLE are simply not seen.
  always_comb begin
    state_d    = state_q;
    do_load_c  = 1'b0;
    do_start_c = 1'b0;
    do_step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          do_load_c = 1'b1;
        end else if (start) begin
          do_start_c = 1'b1;
          state_d    = (amt != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        do_step_c = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      cout   <= 1'b0;
      mode_q <= MODE_HOLD;
      cnt_q  <= '0;
    end else if (do_load_c) begin
      q    <= d;
      cout <= 1'b0;
    end else if (do_start_c) begin
      mode_q <= mode_e'(mode);
      cnt_q  <= amt;
    end else if (do_step_c) begin
      q     <= alu_q_c;
      cout  <= alu_cout_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);

endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg (WIDTH=8, CNT_W=3): directed scenarios plus
// randomized operations against an arithmetic reference model.
module tb_univ_reg;

  logic       clk, rst_n, load, start, sin_l, sin_r;
  logic [7:0] d, q;
  logic [2:0] mode, amt;
  logic       cout, busy, done;
  int         errors, checks;

  univ_reg #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .d(d), .start(start),
    .mode(mode), .amt(amt), .sin_l(sin_l), .sin_r(sin_r),
    .q(q), .cout(cout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; d = v;
    tick();
    load = 1'b0;
  endtask

  // Reference: one step computed with plain integer arithmetic; returns {cout, q}.
  function automatic logic [8:0] ref_step(input int m, input int qv, input int c,
                                          input int sl, input int sr);
    int nq, nc;
    nq = qv; nc = c;
    case (m)
      1: begin nq = (qv * 2 + sr) % 256;           nc = qv / 128; end
      2: begin nq = qv / 2 + sl * 128;             nc = qv % 2;   end
      3: begin nq = (qv * 2 + qv / 128) % 256;     nc = qv / 128; end
      4: begin nq = qv / 2 + (qv % 2) * 128;       nc = qv % 2;   end
      5: begin nq = (qv + 1) % 256;                nc = (qv == 255) ? 1 : 0; end
      6: begin nq = (qv + 255) % 256;              nc = (qv == 0) ? 1 : 0; end
      7: begin nq = qv / 2 + ((qv >= 128) ? 128 : 0); nc = qv % 2; end
      default: ;
    endcase
    return {1'(nc), 8'(nq)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; load = 0; start = 0; d = '0; mode = '0; amt = '0; sin_l = 0; sin_r = 0;
    #3;
    checks++;
    if (q !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_state: q=%h cout=%b busy=%b done=%b required 00/0/0/0", q, cout, busy, done);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_shl();
    do_load(8'h81);
    checks++;
    if (q !== 8'h81 || cout !== 1'b0) begin
      errors++; $display("FAIL load: q=%h cout=%b required 81/0", q, cout);
    end
    start = 1; mode = 3'b001; amt = 3'd1; sin_r = 0;
    tick();
    start = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL shl_accept: busy=%b done=%b required 1/0", busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h02 || cout !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL shl_step: q=%h cout=%b done=%b required 02/1/1", q, cout, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL shl_end: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_rotr();
    logic [7:0] exp_q [3];
    int busy_cycles;
    exp_q[0] = 8'hC0; exp_q[1] = 8'h60; exp_q[2] = 8'h30;
    do_load(8'h81);
    start = 1; mode = 3'b100; amt = 3'd3;
    tick();
    start = 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busy_cycles++;
      checks++;
      if (q !== exp_q[i]) begin
        errors++; $display("FAIL rotr_step%0d: q=%h required %h", i, q, exp_q[i]);
      end
    end
    checks++;
    if (cout !== 1'b0) begin
      errors++; $display("FAIL rotr_cout: cout=%b required 0", cout);
    end
    for (int i = 0; i < 10 && busy; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 4) begin
      errors++; $display("FAIL rotr_busy_len: busy_cycles=%0d required 4", busy_cycles);
    end
  endtask

  task automatic test_inc_dec();
    do_load(8'hFE);
    start = 1; mode = 3'b101; amt = 3'd2;
    tick();
    start = 0;
    tick();
    checks++;
    if (q !== 8'hFF || cout !== 1'b0) begin
      errors++; $display("FAIL inc_step1: q=%h cout=%b required FF/0", q, cout);
    end
    tick();
    checks++;
    if (q !== 8'h00 || cout !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL inc_wrap: q=%h cout=%b done=%b required 00/1/1", q, cout, done);
    end
    tick();
    start = 1; mode = 3'b110; amt = 3'd1;
    tick();
    start = 0;
    tick();
    checks++;
    if (q !== 8'hFF || cout !== 1'b1) begin
      errors++; $display("FAIL dec_wrap: q=%h cout=%b required FF/1", q, cout);
    end
    tick();
  endtask

  task automatic test_asr_amt0();
    do_load(8'h80);
    start = 1; mode = 3'b111; amt = 3'd3;
    tick();
    start = 0;
    tick(); tick(); tick();
    checks++;
    if (q !== 8'hF0 || cout !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL asr: q=%h cout=%b done=%b required F0/0/1", q, cout, done);
    end
    tick();
    start = 1; mode = 3'b011; amt = 3'd0;
    tick();
    start = 0;
    checks++;
    if (q !== 8'hF0 || cout !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL amt0: q=%h cout=%b done=%b busy=%b required F0/0/1/1", q, cout, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL amt0_end: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_priority();
    load = 1; start = 1; d = 8'h5A; mode = 3'b101; amt = 3'd3;
    tick();
    load = 0; start = 0;
    checks++;
    if (q !== 8'h5A || busy !== 1'b0 || cout !== 1'b0) begin
      errors++; $display("FAIL load_wins: q=%h busy=%b cout=%b required 5A/0/0", q, busy, cout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || q !== 8'h5A) begin
      errors++; $display("FAIL start_dropped: busy=%b q=%h required 0/5A", busy, q);
    end
    start = 1; mode = 3'b001; amt = 3'd3; sin_r = 1;
    tick();
    start = 0; load = 1; d = 8'h00; mode = 3'b000; amt = 3'd7;
    tick(); tick(); tick();
    checks++;
    if (q !== 8'hD7 || done !== 1'b1) begin
      errors++; $display("FAIL load_in_run: q=%h done=%b required D7/1", q, done);
    end
    tick();
    load = 0; sin_r = 0;
    checks++;
    if (q !== 8'hD7 || busy !== 1'b0) begin
      errors++; $display("FAIL load_in_fin: q=%h busy=%b required D7/0", q, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    do_load(8'h33);
    start = 1; mode = 3'b011; amt = 3'd7;
    tick();
    start = 0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cout !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: q=%h busy=%b done=%b cout=%b required 00/0/0/0", q, busy, done, cout);
    end
    tick(); tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL no_done_after_reset: cycles_active=%0d required 0", done_seen);
    end
    do_load(8'hA5);
    checks++;
    if (q !== 8'hA5) begin
      errors++; $display("FAIL load_after_reset: q=%h required A5", q);
    end
  endtask

  task automatic test_random();
    int mq, mc, m, a, sl, sr;
    logic [8:0] r;
    mq = 0; mc = 0;
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        do_load(8'($urandom));
        mq = int'(d); mc = 0;
      end
      m = int'($urandom_range(0, 7)); a = int'($urandom_range(0, 7));
      mode = 3'(m); amt = 3'(a); start = 1;
      tick();
      start = 0;
      checks++;
      if (busy !== 1'b1 || done !== 1'(a == 0)) begin
        errors++; $display("FAIL rnd_accept it=%0d: busy=%b done=%b required 1/%0d", it, busy, done, a == 0);
      end
      for (int s = 1; s <= a; s++) begin
        load = 1'($urandom); start = 1'($urandom); d = 8'($urandom);
        mode = 3'($urandom); amt = 3'($urandom);
        sl = int'($urandom_range(0, 1)); sr = int'($urandom_range(0, 1));
        sin_l = 1'(sl); sin_r = 1'(sr);
        tick();
        r = ref_step(m, mq, mc, sl, sr);
        mq = int'(r[7:0]); mc = int'(r[8]);
        checks++;
        if (q !== r[7:0] || cout !== r[8] || done !== 1'(s == a) || busy !== 1'b1) begin
          errors++; $display("FAIL rnd_step it=%0d mode=%0d step=%0d: q=%h cout=%b done=%b busy=%b required %h/%b/%0d/1",
                             it, m, s, q, cout, done, busy, r[7:0], r[8], s == a);
        end
      end
      load = 1'($urandom); start = 1'($urandom);
      tick();
      load = 0; start = 0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 8'(mq) || cout !== 1'(mc)) begin
        errors++; $display("FAIL rnd_end it=%0d: busy=%b done=%b q=%h cout=%b required 0/0/%h/%0d", it, busy, done, q, cout, 8'(mq), mc);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_shl();
    test_rotr();
    test_inc_dec();
    test_asr_amt0();
    test_priority();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
